// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared types and constants for the sprite ROM arbiter: sprite depths, palette index, response tag.
package sprite_rom_arbiter_pkg;

   localparam int GAMEOVER_DEPTH = 253 * 78;
   localparam int PAL_W          = 5;

   typedef logic [PAL_W-1:0] pal_idx_t;

   localparam pal_idx_t TRANSPARENT_IDX = 5'd0;

   // Wide enough for the largest supported requester count (8).
   localparam int RESP_ID_W = 3;

   typedef struct packed {
      logic                 valid;
      logic [RESP_ID_W-1:0] id;
      logic                 oob;
   } resp_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM-side bundle of the sprite ROM arbiter; slave is the arbiter's view, master the client's.
interface sprite_rom_arbiter_if
   import sprite_rom_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 15,
   parameter int DATA_W  = 5
);
   localparam int ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        gnt;
   logic [ADDR_W-1:0]         rom_addr;
   logic [DATA_W-1:0]         rom_data;
   logic                      rvalid;
   logic [ID_W-1:0]           rvalid_id;
   logic [DATA_W-1:0]         rdata;

   modport slave (
      input  req, req_addr, rom_data,
      output gnt, rom_addr, rvalid, rvalid_id, rdata
   );

   modport master (
      output req, req_addr, rom_data,
      input  gnt, rom_addr, rvalid, rvalid_id, rdata
   );

endinterface

// File: rtl/sprite_rom_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo NUM_REQ.
// Zero latency; no state here, the pointer register is owned by the parent.
module sprite_rom_arbiter_rr #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               any_o
);

   function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return ID_W'(s);
   endfunction

   // Walk from the farthest offset back to the pointer so the nearest requester is the last writer.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_i[wrap_idx(ptr_i, i)]) begin
            idx_o = wrap_idx(ptr_i, i);
            any_o = 1'b1;
         end
      end
      gnt_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of one registered-output sprite ROM; one read per clock, responses tagged by requester.
// Grant is same-cycle; data returns ROM_LAT clocks later with out-of-range reads forced transparent.
module sprite_rom_arbiter
   import sprite_rom_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 5,
   parameter int ROM_DEPTH = GAMEOVER_DEPTH,
   parameter int ROM_LAT   = 1
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   sprite_rom_arbiter_if.slave bus
);

   localparam int ID_W = id_width(NUM_REQ);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(ROM_DEPTH);

   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [ID_W-1:0]    arb_idx;
   logic               arb_any;
   logic [ADDR_W-1:0]  gnt_addr;
   resp_t              pipe_d;
   resp_t              pipe_q [ROM_LAT];
   resp_t              resp_out;

   sprite_rom_arbiter_rr #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req_i (bus.req),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   assign gnt_addr = bus.req_addr[int'(arb_idx) * ADDR_W +: ADDR_W];

   always_comb begin
      ptr_d      = ptr_q;
      rom_addr_d = rom_addr_q;
      pipe_d     = '0;
      if (arb_any) begin
         ptr_d      = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
         rom_addr_d = gnt_addr;
         pipe_d.valid = 1'b1;
         pipe_d.id    = RESP_ID_W'(arb_idx);
         pipe_d.oob   = ({1'b0, gnt_addr} >= DEPTH_L);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ptr_q      <= '0;
         rom_addr_q <= '0;
         for (int i = 0; i < ROM_LAT; i++) pipe_q[i] <= '0;
      end else begin
         ptr_q      <= ptr_d;
         rom_addr_q <= rom_addr_d;
         pipe_q[0]  <= pipe_d;
         for (int i = 1; i < ROM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   // Grant and address are combinational, so they are explicitly quiet while reset is held.
   assign bus.gnt      = rst_n_i ? arb_gnt : '0;
   assign bus.rom_addr = !rst_n_i ? '0 : (arb_any ? gnt_addr : rom_addr_q);

   assign resp_out      = pipe_q[ROM_LAT-1];
   assign bus.rvalid    = resp_out.valid;
   assign bus.rvalid_id = resp_out.valid ? ID_W'(resp_out.id) : '0;
   assign bus.rdata     = (resp_out.valid && !resp_out.oob) ? bus.rom_data : DATA_W'(TRANSPARENT_IDX);

   a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(bus.gnt));
   a_ptr_range  : assert property (@(posedge clk_i) disable iff (!rst_n_i) int'(ptr_q) < NUM_REQ);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomised and directed bench for sprite_rom_arbiter against a queue-free behavioural model and a ROM model.
module tb_sprite_rom_arbiter;

   localparam int NREQ  = 4;
   localparam int AW    = 15;
   localparam int DW    = 5;
   localparam int DEPTH = 19734;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic [NREQ-1:0] req_v = '0;
   logic [AW-1:0]   addr_v [NREQ];

   int n_chk  = 0;
   int n_fail = 0;

   sprite_rom_arbiter_if bus ();

   sprite_rom_arbiter dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
      return a[4:0] ^ a[9:5] ^ a[14:10];
   endfunction

   // ROM with one-cycle registered read; contents are arbitrary beyond DEPTH.
   always @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);

   assign bus.req = req_v;
   always_comb begin
      bus.req_addr = '0;
      for (int i = 0; i < NREQ; i++) bus.req_addr[i*AW +: AW] = addr_v[i];
   end

   // Behavioural model state
   int            m_ptr  = 0;
   int            m_gw   = -1;
   logic [AW-1:0] m_last = '0;
   logic          m_vld  = 1'b0;
   int            m_id   = 0;
   logic [AW-1:0] m_addr = '0;

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int o = 0; o < NREQ; o++)
         if (r[(p + o) % NREQ]) return (p + o) % NREQ;
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ptr = 0; m_gw = -1; m_last = '0; m_vld = 1'b0; m_id = 0; m_addr = '0;
      end else begin
         m_gw = pick(req_v, m_ptr);
         if (m_gw >= 0) begin
            m_ptr  = (m_gw + 1) % NREQ;
            m_last = addr_v[m_gw];
            m_vld  = 1'b1;
            m_id   = m_gw;
            m_addr = addr_v[m_gw];
         end else begin
            m_vld = 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model-vs-DUT compare on every falling edge
   always @(negedge clk) begin
      int w;
      logic [NREQ-1:0] e_gnt;
      logic [AW-1:0]   e_addr;
      logic [DW-1:0]   e_data;
      w      = rst_n ? pick(req_v, m_ptr) : -1;
      e_gnt  = (w >= 0) ? NREQ'(1) << w : '0;
      e_addr = !rst_n ? '0 : ((w >= 0) ? addr_v[w] : m_last);
      e_data = (m_vld && m_addr < DEPTH) ? rom_word(m_addr) : '0;
      chk("gnt", 32'(bus.gnt), 32'(e_gnt));
      chk("rom_addr", 32'(bus.rom_addr), 32'(e_addr));
      chk("rvalid", 32'(bus.rvalid), 32'(m_vld));
      chk("rvalid_id", 32'(bus.rvalid_id), m_vld ? m_id : 0);
      chk("rdata", 32'(bus.rdata), 32'(e_data));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_v = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      case ($urandom % 4)
         0:       return AW'(19730 + $urandom % 10);
         1:       return AW'(32767 - $urandom % 4);
         2:       return AW'($urandom);
         default: return AW'($urandom % 256);
      endcase
   endfunction

   initial begin
      for (int i = 0; i < NREQ; i++) addr_v[i] = '0;
      @(negedge clk);
      chk("reset_rvalid", 32'(bus.rvalid), 0);
      chk("reset_gnt", 32'(bus.gnt), 0);
      chk("reset_rom_addr", 32'(bus.rom_addr), 0);
      do_reset();

      // Single requester 2, address 100
      repeat (3) cyc();
      req_v = 4'b0100; addr_v[2] = 15'd100;
      @(negedge clk);
      chk("t1_gnt", 32'(bus.gnt), 32'b0100);
      chk("t1_rom_addr", 32'(bus.rom_addr), 100);
      cyc(); req_v = '0;
      @(negedge clk);
      chk("t1_rvalid", 32'(bus.rvalid), 1);
      chk("t1_id", 32'(bus.rvalid_id), 2);
      chk("t1_rdata", 32'(bus.rdata), 7);

      // Bring pointer back to 0 via requester 3
      cyc(); req_v = 4'b1000; addr_v[3] = 15'd5;
      @(negedge clk);
      chk("t2_pre_gnt", 32'(bus.gnt), 32'b1000);
      cyc(); req_v = '0;

      // All requesters continuously, fresh address every grant
      for (int c = 0; c < 8; c++) begin
         cyc();
         req_v = 4'b1111;
         for (int i = 0; i < NREQ; i++) addr_v[i] = AW'(1000 + 4 * c + i);
         @(negedge clk);
         chk("t2_gnt", 32'(bus.gnt), 32'(1) << (c % 4));
         if (c > 0) chk("t2_id", 32'(bus.rvalid_id), (c - 1) % 4);
      end
      cyc(); req_v = '0;
      @(negedge clk);
      chk("t2_last_id", 32'(bus.rvalid_id), 3);

      // Requesters 1 and 3 with pointer at 2 after a grant to 1
      cyc(); req_v = 4'b0010; addr_v[1] = 15'd40;
      @(negedge clk);
      chk("t3_gnt1", 32'(bus.gnt), 32'b0010);
      cyc(); req_v = 4'b1010; addr_v[1] = 15'd41; addr_v[3] = 15'd42;
      @(negedge clk);
      chk("t3_gnt3", 32'(bus.gnt), 32'b1000);
      cyc(); req_v = 4'b0011; addr_v[0] = 15'd43;
      @(negedge clk);
      chk("t3_wrap", 32'(bus.gnt), 32'b0001);
      cyc(); req_v = 4'b0010;
      @(negedge clk);
      chk("t3_then1", 32'(bus.gnt), 32'b0010);
      cyc(); req_v = '0;

      // Out-of-range boundary on requester 0
      cyc(); req_v = 4'b0001; addr_v[0] = 15'd19734;
      cyc(); addr_v[0] = 15'd32767;
      @(negedge clk);
      chk("t4_oob_vld", 32'(bus.rvalid), 1);
      chk("t4_oob_19734", 32'(bus.rdata), 0);
      cyc(); addr_v[0] = 15'd19733;
      @(negedge clk);
      chk("t4_oob_32767", 32'(bus.rdata), 0);
      cyc(); req_v = '0;
      @(negedge clk);
      chk("t4_last_valid", 32'(bus.rdata), 14);

      // Idle after a read of address 55
      cyc(); req_v = 4'b0001; addr_v[0] = 15'd55;
      cyc(); req_v = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t6_gnt", 32'(bus.gnt), 0);
         chk("t6_rom_addr", 32'(bus.rom_addr), 55);
         if (c > 0) chk("t6_rvalid", 32'(bus.rvalid), 0);
         cyc();
      end
      req_v = 4'b1111;
      @(negedge clk);
      chk("t6_ptr_kept", 32'(bus.gnt), 32'b0010);
      cyc(); req_v = '0;

      // Reset right after a grant has been loaded
      repeat (3) cyc();
      req_v = 4'b0100; addr_v[2] = 15'd300;
      @(negedge clk);
      chk("t5_gnt", 32'(bus.gnt), 32'b0100);
      @(posedge clk); #1;
      rst_n = 1'b0; req_v = '0;
      @(negedge clk);
      chk("t5_rst_rvalid", 32'(bus.rvalid), 0);
      chk("t5_rst_rom_addr", 32'(bus.rom_addr), 0);
      chk("t5_rst_rdata", 32'(bus.rdata), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("t5_no_stale", 32'(bus.rvalid), 0);
      cyc(); req_v = 4'b1111;
      @(negedge clk);
      chk("t5_ptr0", 32'(bus.gnt), 32'b0001);
      cyc(); req_v = '0;

      // Random traffic obeying the hold-until-granted protocol
      for (int c = 0; c < 2000; c++) begin
         cyc();
         if (c == 700) begin
            do_reset();
         end else begin
            for (int i = 0; i < NREQ; i++) begin
               if (req_v[i] && m_gw == i) begin
                  if ($urandom % 2 == 0) req_v[i] = 1'b0;
                  else addr_v[i] = rnd_addr();
               end else if (!req_v[i] && ($urandom % 3 == 0)) begin
                  req_v[i]  = 1'b1;
                  addr_v[i] = rnd_addr();
               end
            end
         end
      end
      cyc(); req_v = '0;
      repeat (3) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
Shares one synchronous sprite/overlay ROM (5-bit palette index, 15-bit address, 1-cycle registered read) among several requesters, e.g. the game-over overlay, the HUD and the enemy sprite fetchers.
Arbitrates round-robin, issues at most one ROM read per clock, and returns data tagged with the requester ID.
Sits between the VGA-side sprite fetch logic and the ROM instance.
Substitutes the transparent palette index for out-of-range addresses.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 15, ROM address width
DATA_W, 5, palette index width
ROM_DEPTH, 19734, valid word count (253*78); addresses >= ROM_DEPTH are out of range
ROM_LAT, 1, ROM read latency in clocks (registered output)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester read request, held until granted
req_addr  in  NUM_REQ*ADDR_W  packed addresses; slice i belongs to req[i]; stable while req[i] is high
gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as accepted request
rom_addr  out  ADDR_W  address to ROM read_address
rom_data  in  DATA_W  ROM data_Out
rvalid  out  1  read data valid
rvalid_id  out  $clog2(NUM_REQ)  requester index of rdata
rdata  out  DATA_W  returned palette index

Behaviour:
- Reset (Reset_n=0, async): rr pointer=0, response pipeline cleared; rvalid=0, rvalid_id=0, gnt=0, rom_addr=0, rdata=0.
- Arbitration, cycle T: search req starting at pointer, wrapping modulo NUM_REQ; first set bit k wins.
  - gnt[k]=1, rom_addr=req_addr slice k.
  - At the T clock edge, pointer <= (k+1) mod NUM_REQ.
- No request: gnt=0, rom_addr holds its last value (registered copy), pointer unchanged.
- Requester protocol: a requester drops req on the cycle after gnt, or keeps it high for back-to-back reads with a new address. Each grant is exactly one read.
- Pipeline: ROM_LAT-deep shift register of {valid, id, oob}, loaded at the T edge.
  - oob=1 when the granted address >= ROM_DEPTH.
  - At T+ROM_LAT: rvalid=1, rvalid_id=k, rdata = oob ? 0 : rom_data. rdata is combinational from rom_data; valid/id/oob are registered.
- Throughput: 1 read/clock sustained. With all requesters asserted continuously, each is served once every NUM_REQ cycles.
- Single requester: granted every cycle.
- Pointer wrap: after a grant to NUM_REQ-1, the pointer is 0.
- rvalid=0: rdata=0, rvalid_id=0.
- Reset mid-operation: in-flight reads are discarded. No rvalid appears after reset deassertion for reads granted before reset.
- Address range checks use full ADDR_W compare; no truncation.

Decomposition:
- Package sprite_pkg: ROM_DEPTH constants per sprite (GAMEOVER_DEPTH=19734), TRANSPARENT_IDX=5'd0, palette index typedef, and the resp_t struct {valid, id, oob}.
- Sub-module rr_arbiter:
  - Inputs: NUM_REQ req, pointer.
  - Outputs: one-hot gnt, encoded index, any.
  - Combinational; pointer register lives in the parent.

Test Plan:
1. Reset then single req[2] with addr=100 at cycle 5 -> gnt=4'b0100 at cycle 5, rom_addr=100, rvalid=1 with rvalid_id=2 and rdata=mem[100] at cycle 6.
2. req=4'b1111 held 8 cycles, pointer 0 -> grants 0,1,2,3,0,1,2,3 one-hot in order; rvalid every cycle with matching ids one cycle later.
3. req[1] and req[3] both set, pointer=2 after a grant to 1 -> requester 3 granted first, then 1; pointer wraps to 0 after 3.
4. req[0] addr=19734, then addr=32767 -> rvalid=1, rdata=0 for both; addr=19733 -> rdata=mem[19733].
5. Grant at cycle 10, Reset_n pulsed low at cycle 10.5 for one cycle -> no rvalid at cycle 11; all outputs 0 during reset; pointer restarts at 0.
6. req=0 for 5 cycles after a read of addr 55 -> gnt=0, rvalid=0, rom_addr stays 55, pointer unchanged.
